data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//  Responder end of the datapath's data-memory interface. Accepts one load/store
//  request at a time from the datapath: address = ALUResult, store data = WriteData.
//  Returns load data on the ReadData path after a programmable number of wait states.
//  Backed by an internal word-addressed RAM; intended to replace the zero-latency
//  data memory so the control unit can be exercised with stalls.
// PARAMETERS
//  DEPTH_LOG2   10           log2 of RAM depth in 32-bit words (1024 words)
//  WAIT_CYCLES  2            wait states between accept and response (0..15)
//  BASE_ADDR    32'h0000_0000 byte address mapped to RAM word 0
// PORTS
//  CLK        in   1   clock, all state updates on rising edge
//  reset      in   1   synchronous reset, active-low (0 = reset)
//  req_valid  in   1   datapath presents a request
//  req_we     in   1   1 = store, 0 = load
//  req_addr   in   32  byte address
//  req_wdata  in   32  store data
//  req_ready  out  1   responder can accept a request this cycle
//  rsp_valid  out  1   one-cycle pulse: request completed
//  rsp_rdata  out  32  load data, valid while rsp_valid=1
//  rsp_err    out  1   access error, valid with rsp_valid (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (reset=0 at edge): state=IDLE, req_ready=0 during reset, rsp_valid=0,
//    rsp_rdata=0, rsp_err=0, wait counter=0. RAM contents NOT cleared.
//  - FSM: IDLE -> BUSY -> RESP -> IDLE.
//    IDLE: req_ready=1. On edge with req_valid=1, latch we/addr/wdata.
//      Go to BUSY with cnt=WAIT_CYCLES, or to RESP directly if WAIT_CYCLES=0.
//    BUSY: req_ready=0; cnt decrements each edge; at cnt==1, go to RESP.
//    RESP: rsp_valid=1 for exactly one cycle, req_ready=0; next edge -> IDLE.
//  - Latency: request accepted at edge t0, rsp_valid high during the cycle that
//    follows edge t0+WAIT_CYCLES. Minimum spacing between accepts:
//    WAIT_CYCLES+2 edges. No back-to-back accept in RESP.
//  - RAM access happens on the edge entering RESP.
//    Store: RAM[idx] <= wdata; rsp_rdata <= 0.
//    Load:  rsp_rdata <= RAM[idx].
//  - idx = (addr - BASE_ADDR)[DEPTH_LOG2+1:2]; addr[1:0] ignored unless macro enabled.
//  - Out of range (addr - BASE_ADDR >= 4<<DEPTH_LOG2, unsigned 32-bit):
//    load returns 32'h0, store dropped, rsp_err=1. Still responds normally.
//  - Read-after-write: a load following a store to the same idx returns new data.
//  - Request inputs are don't-care outside IDLE; changes there have no effect.
//  - Reset mid-operation (BUSY/RESP): transaction abandoned, no response issued.
//    A pending store is not written unless its RAM edge already occurred.
//  - rsp_rdata holds its value until the next RESP or reset.
// CONFIGURATION
//  DMEM_ALIGN_CHECK_EN defined:
//    addr[1:0]!=0 is an error. Load returns 0, store dropped, rsp_err=1.
//  DMEM_ALIGN_CHECK_EN undefined:
//    addr[1:0] ignored (word access at aligned idx). rsp_err flags range errors only.
// TESTING
//  1 Reset: hold reset=0 for 3 edges -> rsp_valid=0, rsp_rdata=0, rsp_err=0;
//    req_ready=1 on first cycle after release.
//  2 WAIT=2: store 32'hDEADBEEF @0x10 accepted at t0 -> rsp_valid pulse after t0+2
//    only; then load @0x10 -> rsp_rdata=32'hDEADBEEF, rsp_err=0.
//  3 WAIT=0: store 0x1 @0x0, then load @0x0 -> each rsp_valid one cycle after
//    accept, read=0x1; req_valid held high -> accepts every 2 edges.
//  4 Out of range (DEPTH_LOG2=10): store 0x55 @0x1000 -> rsp_err=1;
//    load @0x1000 -> 0, rsp_err=1; load @0x0 unchanged.
//  5 Reset asserted in BUSY during store 0xAA @0x8 -> no rsp_valid;
//    load @0x8 returns prior value.
//  6 Store 0x77 @0x6: with DMEM_ALIGN_CHECK_EN -> rsp_err=1, RAM[1] unchanged;
//    without it -> RAM[1]=0x77, rsp_err=0.

Source files
------------

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one load/store at a time and answers after
// WAIT_CYCLES wait states from an internal word-addressed RAM.
// Optional build macro DMEM_ALIGN_CHECK_EN: flag addr[1:0] != 0 as an access error.
module data_mem_responder #(
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned Depth    = 1 << DEPTH_LOG2;
  localparam logic [3:0]  WaitCnt  = 4'(WAIT_CYCLES);
  // Byte span of the RAM, kept 33 bits wide so the compare cannot wrap.
  localparam logic [32:0] RangeLim = 33'd4 << DEPTH_LOG2;

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic [31:0] rdata_q;
  logic        err_q;

  logic [31:0] mem [Depth];

  logic        accept;
  logic        enter_resp;
  logic        acc_we;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic [31:0] offset;
  logic [DEPTH_LOG2-1:0] idx;
  logic        out_of_range;
  logic        misalign;
  logic        acc_err;
  logic        unused_offset_lsb;

  // FSM state and wait counter register
  always_ff @(posedge CLK) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM next-state and wait counter update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (WAIT_CYCLES == 0) begin
            state_d = StResp;
          end else begin
            state_d = StBusy;
            cnt_d   = WaitCnt;
          end
        end
      end
      StBusy: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = StResp;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // FSM outputs; both are held low while reset is asserted
  always_comb begin
    req_ready = reset && (state_q == StIdle);
    rsp_valid = reset && (state_q == StResp);
  end

  assign accept     = req_ready && req_valid;
  assign enter_resp = reset && (state_d == StResp) && (state_q != StResp);

  // Latch the request on acceptance; inputs are ignored outside IDLE
  always_ff @(posedge CLK) begin
    if (!reset) begin
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
    end else if (accept) begin
      we_q    <= req_we;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  // Zero wait states access RAM on the accept edge, so use live inputs there.
  always_comb begin
    if (state_q == StIdle) begin
      acc_we    = req_we;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
    end else begin
      acc_we    = we_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
    end
  end

  assign offset       = acc_addr - BASE_ADDR;
  assign idx          = offset[DEPTH_LOG2+1:2];
  assign out_of_range = {1'b0, offset} >= RangeLim;

`ifdef DMEM_ALIGN_CHECK_EN
  assign misalign = (acc_addr[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  assign acc_err           = out_of_range || misalign;
  assign unused_offset_lsb = ^offset[1:0];

  // RAM write port; contents are never cleared by reset
  always_ff @(posedge CLK) begin
    if (enter_resp && acc_we && !acc_err) begin
      mem[idx] <= acc_wdata;
    end
  end

  // Response data/error, captured on the edge entering RESP and held until the next one
  always_ff @(posedge CLK) begin
    if (!reset) begin
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else if (enter_resp) begin
      err_q <= acc_err;
      if (acc_we || acc_err) begin
        rdata_q <= 32'h0;
      end else begin
        rdata_q <= mem[idx];
      end
    end
  end

  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: a WAIT_CYCLES=2 instance (a_*) for most tests
// and a WAIT_CYCLES=0 instance (b_*) for the zero-wait streaming case.
module tb_data_mem_responder;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        reset;
  logic        a_valid, a_we, a_ready, a_rsp_valid, a_err;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic        b_valid, b_we, b_ready, b_rsp_valid, b_err;
  logic [31:0] b_addr, b_wdata, b_rdata;

  int checks = 0;
  int errors = 0;

  data_mem_responder #(
    .DEPTH_LOG2 (10),
    .WAIT_CYCLES(2),
    .BASE_ADDR  (32'h0)
  ) dut_a (
    .CLK      (CLK),
    .reset    (reset),
    .req_valid(a_valid),
    .req_we   (a_we),
    .req_addr (a_addr),
    .req_wdata(a_wdata),
    .req_ready(a_ready),
    .rsp_valid(a_rsp_valid),
    .rsp_rdata(a_rdata),
    .rsp_err  (a_err)
  );

  data_mem_responder #(
    .DEPTH_LOG2 (10),
    .WAIT_CYCLES(0),
    .BASE_ADDR  (32'h0)
  ) dut_b (
    .CLK      (CLK),
    .reset    (reset),
    .req_valid(b_valid),
    .req_we   (b_we),
    .req_addr (b_addr),
    .req_wdata(b_wdata),
    .req_ready(b_ready),
    .rsp_valid(b_rsp_valid),
    .rsp_rdata(b_rdata),
    .rsp_err  (b_err)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Issue one request on dut_a; lat = cycles from accept edge to rsp_valid (99 = none).
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat,
                        output logic pulse_one);
    int n;
    n = 0;
    while (!a_ready && n < 20) begin
      step();
      n++;
    end
    a_valid = 1'b1;
    a_we    = we;
    a_addr  = addr;
    a_wdata = wdata;
    step();
    // Scribble on the inputs; the DUT must use its latched copy.
    a_valid   = 1'b0;
    a_we      = ~we;
    a_addr    = 32'h0000_0F0C;
    a_wdata   = 32'h5A5A_A5A5;
    lat       = 0;
    rdata     = 32'h0;
    err       = 1'b0;
    pulse_one = 1'b0;
    while (!a_rsp_valid && lat < 20) begin
      step();
      lat++;
    end
    if (a_rsp_valid) begin
      rdata = a_rdata;
      err   = a_err;
      step();
      pulse_one = !a_rsp_valid;
    end else begin
      lat = 99;
    end
  endtask

  task automatic test_reset();
    logic ready_during;
    reset   = 1'b0;
    a_valid = 1'b0; a_we = 1'b0; a_addr = 32'h0; a_wdata = 32'h0;
    b_valid = 1'b0; b_we = 1'b0; b_addr = 32'h0; b_wdata = 32'h0;
    step(); step(); step();
    ready_during = a_ready;
    checks++;
    if (a_rsp_valid !== 1'b0 || a_rdata !== 32'h0 || a_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b rdata=%h err=%b, want 0/0/0",
               a_rsp_valid, a_rdata, a_err);
    end
    checks++;
    if (ready_during !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_low: got %b, want 0", ready_during);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (a_ready !== 1'b1 || b_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got a=%b b=%b, want 1/1", a_ready, b_ready);
    end
  endtask

  task automatic test_wait2();
    logic [31:0] rd;
    logic        er, p1;
    int          lat;
    do_req(1'b1, 32'h10, 32'hDEAD_BEEF, rd, er, lat, p1);
    checks++;
    if (lat != 2 || !p1 || er !== 1'b0 || rd !== 32'h0) begin
      errors++;
      $display("FAIL wait2_store: got lat=%0d pulse1=%b err=%b rdata=%h, want 2/1/0/0",
               lat, p1, er, rd);
    end
    do_req(1'b0, 32'h10, 32'h0, rd, er, lat, p1);
    checks++;
    if (lat != 2 || !p1 || er !== 1'b0 || rd !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL wait2_load: got lat=%0d pulse1=%b err=%b rdata=%h, want 2/1/0/deadbeef",
               lat, p1, er, rd);
    end
    step(); step();
    checks++;
    if (a_rdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL rdata_hold: got %h, want deadbeef", a_rdata);
    end
  endtask

  task automatic test_back_to_back();
    int n, gap;
    a_valid = 1'b1; a_we = 1'b0; a_addr = 32'h10; a_wdata = 32'h0;
    n = 0;
    while (!a_rsp_valid && n < 20) begin
      step();
      n++;
    end
    step();
    gap = 1;
    while (!a_rsp_valid && gap < 20) begin
      step();
      gap++;
    end
    a_valid = 1'b0;
    checks++;
    if (gap != 4) begin
      errors++;
      $display("FAIL back_to_back_spacing: got %0d edges, want 4", gap);
    end
    step(); step();
  endtask

  task automatic test_wait0();
    logic v0, r0, v1, r1, v2;
    logic [31:0] d2;
    b_valid = 1'b1; b_we = 1'b1; b_addr = 32'h0; b_wdata = 32'h1;
    step();
    v0 = b_rsp_valid; r0 = b_ready;
    b_we = 1'b0; b_wdata = 32'h0;
    step();
    v1 = b_rsp_valid; r1 = b_ready;
    step();
    v2 = b_rsp_valid; d2 = b_rdata;
    b_valid = 1'b0;
    checks++;
    if (v0 !== 1'b1 || r0 !== 1'b0 || b_err !== 1'b0) begin
      errors++;
      $display("FAIL wait0_store_rsp: got valid=%b ready=%b, want 1/0", v0, r0);
    end
    checks++;
    if (v1 !== 1'b0 || r1 !== 1'b1) begin
      errors++;
      $display("FAIL wait0_idle_gap: got valid=%b ready=%b, want 0/1", v1, r1);
    end
    checks++;
    if (v2 !== 1'b1 || d2 !== 32'h1) begin
      errors++;
      $display("FAIL wait0_load: got valid=%b rdata=%h, want 1/00000001", v2, d2);
    end
    step();
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd;
    logic        er, p1;
    int          lat;
    do_req(1'b1, 32'h0, 32'h1234_5678, rd, er, lat, p1);
    do_req(1'b1, 32'h1000, 32'h55, rd, er, lat, p1);
    checks++;
    if (lat != 2 || er !== 1'b1) begin
      errors++;
      $display("FAIL oor_store: got lat=%0d err=%b, want 2/1", lat, er);
    end
    do_req(1'b0, 32'h1000, 32'h0, rd, er, lat, p1);
    checks++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      errors++;
      $display("FAIL oor_load: got err=%b rdata=%h, want 1/0", er, rd);
    end
    do_req(1'b0, 32'h0, 32'h0, rd, er, lat, p1);
    checks++;
    if (er !== 1'b0 || rd !== 32'h1234_5678) begin
      errors++;
      $display("FAIL oor_word0_intact: got err=%b rdata=%h, want 0/12345678", er, rd);
    end
    do_req(1'b1, 32'hFFC, 32'hCAFE_0001, rd, er, lat, p1);
    do_req(1'b0, 32'hFFC, 32'h0, rd, er, lat, p1);
    checks++;
    if (er !== 1'b0 || rd !== 32'hCAFE_0001) begin
      errors++;
      $display("FAIL last_word: got err=%b rdata=%h, want 0/cafe0001", er, rd);
    end
  endtask

  task automatic test_reset_midop();
    logic [31:0] rd;
    logic        er, p1, seen;
    int          lat;
    do_req(1'b1, 32'h8, 32'h11, rd, er, lat, p1);
    do_req(1'b0, 32'h8, 32'h0, rd, er, lat, p1);
    a_valid = 1'b1; a_we = 1'b1; a_addr = 32'h8; a_wdata = 32'hAA;
    step();
    a_valid = 1'b0;
    reset   = 1'b0;
    step();
    reset = 1'b1;
    checks++;
    if (a_rdata !== 32'h0) begin
      errors++;
      $display("FAIL midop_rdata_cleared: got %h, want 0", a_rdata);
    end
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      seen = seen | a_rsp_valid;
      step();
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL midop_no_rsp: got rsp_valid seen=%b, want 0", seen);
    end
    do_req(1'b0, 32'h8, 32'h0, rd, er, lat, p1);
    checks++;
    if (rd !== 32'h11) begin
      errors++;
      $display("FAIL midop_ram_intact: got %h, want 00000011", rd);
    end
  endtask

  task automatic test_align();
    logic [31:0] rd, exp_rd;
    logic        er, exp_er;
    logic        p1;
    int          lat;
`ifdef DMEM_ALIGN_CHECK_EN
    exp_er = 1'b1;
    exp_rd = 32'h5;
`else
    exp_er = 1'b0;
    exp_rd = 32'h77;
`endif
    do_req(1'b1, 32'h4, 32'h5, rd, er, lat, p1);
    do_req(1'b1, 32'h6, 32'h77, rd, er, lat, p1);
    checks++;
    if (er !== exp_er) begin
      errors++;
      $display("FAIL align_store_err: got %b, want %b", er, exp_er);
    end
    do_req(1'b0, 32'h4, 32'h0, rd, er, lat, p1);
    checks++;
    if (rd !== exp_rd || er !== 1'b0) begin
      errors++;
      $display("FAIL align_word1: got rdata=%h err=%b, want %h/0", rd, er, exp_rd);
    end
  endtask

  initial begin
    test_reset();
    test_wait2();
    test_back_to_back();
    test_wait0();
    test_out_of_range();
    test_reset_midop();
    test_align();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
